// File: rtl/shot_resolver.sv
// Opponent-side shot resolver: snapshots the ship board, steers a cursor,
// resolves shots as hit/miss/repeat and drives a segment-mapped overlay.
module shot_resolver #(
  parameter int BLINK_DIV = 12500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] positions,
  input  logic        arm,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        fire,
  output logic [4:0]  cursor,
  output logic        hit,
  output logic        miss,
  output logic        repeat_shot,
  output logic [4:0]  remaining,
  output logic        game_over,
  output logic [27:0] display,
  output logic [1:0]  state_dbg
);

  // All control inputs are single-cycle pulses; there is no ready/valid
  // back-pressure, a pulse is acted on only in the state that listens to it.
  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    AIM     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  state_t        state_q;
  logic [4:0]    cursor_q;
  logic [4:0]    target_q;
  logic [4:0]    remaining_q;
  logic [27:0]   board_q;
  logic [27:0]   shots_q;
  logic [27:0]   hits_q;
  logic          hit_q;
  logic          miss_q;
  logic          repeat_q;
  logic          game_over_q;
  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic [27:0]   display_d;
  logic [4:0]    pos_count;

  function automatic logic [4:0] popcount28(input logic [27:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 28; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  assign pos_count = popcount28(positions);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNARMED;
      cursor_q    <= '0;
      target_q    <= '0;
      remaining_q <= '0;
      board_q     <= '0;
      shots_q     <= '0;
      hits_q      <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      repeat_q    <= 1'b0;
      game_over_q <= 1'b0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      repeat_q <= 1'b0;
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      case (state_q)
        UNARMED: begin
          if (arm && pos_count != 5'd0) begin
            board_q     <= positions;
            remaining_q <= pos_count;
            shots_q     <= '0;
            hits_q      <= '0;
            cursor_q    <= '0;
            // Restart blink visible so the cursor shows immediately.
            cnt_q       <= '0;
            phase_q     <= 1'b1;
            state_q     <= AIM;
          end
        end
        AIM: begin
          if (fire) begin
            target_q <= cursor_q;
            state_q  <= RESOLVE;
          end else if (btn_next && !btn_prev) begin
            cursor_q <= (cursor_q == 5'd27) ? 5'd0 : cursor_q + 5'd1;
          end else if (btn_prev && !btn_next) begin
            cursor_q <= (cursor_q == 5'd0) ? 5'd27 : cursor_q - 5'd1;
          end
        end
        RESOLVE: begin
          state_q <= AIM;
          if (shots_q[target_q]) begin
            repeat_q <= 1'b1;
          end else begin
            shots_q[target_q] <= 1'b1;
            if (board_q[target_q]) begin
              hits_q[target_q] <= 1'b1;
              remaining_q      <= remaining_q - 5'd1;
              hit_q            <= 1'b1;
              if (remaining_q == 5'd1) begin
                state_q     <= DONE;
                game_over_q <= 1'b1;
              end
            end else begin
              miss_q <= 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: state_q <= UNARMED;
      endcase
    end
  end

  // Cursor bit shows the blink phase even over an already-hit cell.
  always_comb begin
    display_d = hits_q;
    case (state_q)
      UNARMED: display_d = positions;
      AIM, RESOLVE: display_d[cursor_q] = phase_q;
      default: display_d = hits_q;
    endcase
  end

  assign cursor      = cursor_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign repeat_shot = repeat_q;
  assign remaining   = remaining_q;
  assign game_over   = game_over_q;
  assign display     = display_d;
  assign state_dbg   = state_q;

endmodule

// File: doc/shot_resolver.md
Name: shot_resolver

Overview:
- Reader side of the board-setting path. Takes the 28-bit segment-mapped ship board produced by the set stage (bit d*7+s = segment s of digit d) and snapshots it when armed.
- Lets the opposing player move a cursor over the 28 cells and fire. Resolves each shot as hit, miss or repeat, counts remaining ship cells, and flags game over.
- Emits a 28-bit overlay (hits solid, cursor blinking) in the same bit format, so it feeds DisplayDriverFSM directly.

Parameters:
- BLINK_DIV, default 12500000, clk cycles per half-period of cursor blink (must be ≥2; benches use 4).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high; overrides all other inputs.
- positions  input  28  ship board from the set stage; sampled only on arm.
- arm  input  1  single-cycle pulse; latch board and start play.
- btn_next  input  1  single-cycle pulse; cursor +1.
- btn_prev  input  1  single-cycle pulse; cursor −1.
- fire  input  1  single-cycle pulse; shoot at cursor cell.
- cursor  output  5  current target cell, 0..27.
- hit  output  1  one-cycle pulse: shot struck a ship cell.
- miss  output  1  one-cycle pulse: shot hit empty water.
- repeat_shot  output  1  one-cycle pulse: cell already fired on.
- remaining  output  5  unhit ship cells left.
- game_over  output  1  level; all ship cells hit.
- display  output  28  overlay to the display driver.

Behaviour:
- All inputs are synchronous and already debounced. Every state and register update happens on the rising edge of clk.
- Reset (any state, including mid-RESOLVE), after the next edge:
  - state UNARMED; cursor=0; remaining=0; internal board, shots and hits registers =0.
  - hit=miss=repeat_shot=0; game_over=0; blink counter=0, phase=0.
- States: UNARMED, AIM, RESOLVE, DONE.
- UNARMED:
  - display=positions (pass-through preview); btn_next, btn_prev and fire are ignored.
  - arm with popcount(positions)≠0: board<=positions, remaining<=popcount (0..28 fits 5 bits), shots<=0, hits<=0, cursor<=0, go to AIM.
  - arm with popcount=0: ignored, stay in UNARMED.
- AIM:
  - fire: target<=cursor, go to RESOLVE. fire has priority, so a move pulse in the same cycle is dropped.
  - Otherwise btn_next alone: cursor<=(cursor==27)?0:cursor+1.
  - Otherwise btn_prev alone: cursor<=(cursor==0)?27:cursor−1.
  - btn_next and btn_prev together: no move.
  - arm is ignored.
- RESOLVE (exactly one cycle; all inputs ignored):
  - If shots[target]=1: repeat_shot pulses; no other change; go to AIM.
  - Else shots[target]<=1, then:
    - board[target]=1: hits[target]<=1, remaining<=remaining−1, hit pulses. If remaining was 1, go to DONE, else go to AIM.
    - board[target]=0: miss pulses; go to AIM.
- Result timing: the result pulses are registered. Fire sampled at edge k → RESOLVE during cycle k..k+1 → pulse high for exactly the cycle between edges k+1 and k+2. At most one of hit/miss/repeat_shot is ever high.
- DONE: game_over=1; cursor frozen; all inputs except reset ignored; display=hits.
- display in AIM and RESOLVE:
  - bit i = hits[i] for i≠cursor.
  - bit cursor = blink phase, so the cursor blinks even over a hit cell.
- Blink:
  - The counter runs in every state, counting 0..BLINK_DIV−1; phase toggles on wrap.
  - On entering AIM from UNARMED: counter=0 and phase=1, so the cursor is visible immediately.

Test Plan:
- Reset with all inputs at 0 → cursor=0, remaining=0, game_over=0, all pulses 0; display tracks positions=28'h0000081 bit-for-bit.
- Arm with positions=28'h0000003 → remaining=2, cursor=0. Then btn_prev → cursor=27. Then btn_next → cursor=0. Then btn_next and btn_prev in the same cycle → cursor stays 0.
- Same board, fire at cursor 0 → hit pulse exactly one cycle (2nd edge after fire), remaining=1. Move to cell 5 and fire → miss pulse, remaining=1. Fire at cell 5 again → repeat_shot pulse, remaining unchanged.
- Fire at cell 1 → hit, remaining=0, game_over=1 the same cycle. Later btn_next, fire and arm pulses → cursor, pulses and display=28'h0000003 all unchanged.
- fire and btn_next in the same cycle at cursor 3 → shot resolves on cell 3 and cursor stays 3. Reset asserted during RESOLVE → no result pulse, state UNARMED, all outputs at reset values.
- BLINK_DIV=4, armed, cursor=2, no hits → display bit 2 toggles every 4 cycles and all other bits stay 0. Arm with positions=0 → ignored, state stays UNARMED.
